// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump
// Purpose  : Streams register-file entries 0..LAST_REG as a ready/valid byte stream;
//            optional trailing XOR checksum byte (macro REG_DUMP_CSUM_EN).
// Revision : 1.0
// ============================================================================
module reg_dump #(
    parameter int LAST_REG = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] ra,
    input  logic [7:0] read_a,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = 4'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        FIN   = 3'd3
`ifdef REG_DUMP_CSUM_EN
        ,
        CSUM  = 3'd4
`endif
    } state_t;

    state_t     state_q;
    logic [3:0] index_q;
    logic [3:0] index_d;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       busy_q;
    logic       done_q;
`ifdef REG_DUMP_CSUM_EN
    logic [7:0] csum_q;
`endif

    assign index_d = index_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= 4'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        index_q <= 4'd0;
                        busy_q  <= 1'b1;
`ifdef REG_DUMP_CSUM_EN
                        csum_q  <= 8'h00;
`endif
                    end
                end
                FETCH: begin
                    out_data_q  <= read_a;
                    out_valid_q <= 1'b1;
                    state_q     <= SEND;
`ifdef REG_DUMP_CSUM_EN
                    csum_q      <= csum_q ^ read_a;
`endif
                end
                SEND: begin
                    if (out_ready) begin
                        if (index_q < LAST_IDX) begin
                            index_q     <= index_d;
                            out_valid_q <= 1'b0;
                            state_q     <= FETCH;
                        end else begin
`ifdef REG_DUMP_CSUM_EN
                            // checksum already folds in the last byte fetched
                            out_data_q <= csum_q;
                            state_q    <= CSUM;
`else
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= FIN;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CSUM_EN
                CSUM: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
`endif
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign ra        = index_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// Bench for reg_dump: randomized/directed dumps compared against a queue-based expected stream.
module tb_reg_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, out_ready, sel;
    logic [7:0] regs [16];
    logic [3:0] ra_a, ra_b;
    logic [7:0] rd_a, rd_b, od_a, od_b;
    logic       ov_a, ov_b, bz_a, bz_b, dn_a, dn_b;
    logic [7:0] w_od;
    logic       w_ov, w_busy, w_done;

    int total = 0;
    int bad   = 0;

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];

    reg_dump #(.LAST_REG(15)) u_dut (
        .clk(clk), .rst(rst), .start(start & ~sel), .ra(ra_a), .read_a(rd_a),
        .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
        .busy(bz_a), .done(dn_a)
    );

    reg_dump #(.LAST_REG(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start & sel), .ra(ra_b), .read_a(rd_b),
        .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready),
        .busy(bz_b), .done(dn_b)
    );

    assign w_od   = sel ? od_b : od_a;
    assign w_ov   = sel ? ov_b : ov_a;
    assign w_busy = sel ? bz_b : bz_a;
    assign w_done = sel ? dn_b : dn_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_random();
        regs[0] = 8'h00;
        for (int i = 1; i < 16; i++) regs[i] = 8'($urandom);
    endtask

    // mode 0: ready always high, 1: ready pattern 0,0,1, 2: random ready
    task automatic run_dump(input string name, input int mode, input int restart_at);
        logic [7:0] got[$];
        logic [7:0] expq[$];
        logic [7:0] cs;
        logic [7:0] hold;
        int last, busy_n, done_n, done_cyc, xfer_cyc, extra;
        bit stall, finished;
        last = sel ? 3 : 15;
        cs = 8'h00;
        extra = 0;
        expq = {};
        for (int i = 0; i <= last; i++) begin
            expq.push_back(regs[i]);
            cs ^= regs[i];
        end
`ifdef REG_DUMP_CSUM_EN
        expq.push_back(cs);
        extra = 1;
`endif
        got = {};
        busy_n = 0; done_n = 0; done_cyc = -100; xfer_cyc = -1;
        stall = 1'b0; finished = 1'b0; hold = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (!w_busy) begin
                finished = 1'b1;
            end else begin
                if (w_done) begin
                    done_n++;
                    done_cyc = cyc;
                end else begin
                    busy_n++;
                end
                if (stall) begin
                    chk({name, "_stall_data"}, w_od, hold);
                    chk({name, "_stall_valid"}, w_ov, 1);
                end
                if (sel) chk({name, "_ra_max"}, ra_b <= 4'd3, 1);
                if (w_ov && out_ready) begin
                    got.push_back(w_od);
                    xfer_cyc = cyc;
                end
                stall = w_ov && !out_ready;
                hold  = w_od;
                @(posedge clk); #1;
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (cyc % 3 == 2);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                start = (restart_at > 0) && (got.size() == restart_at);
            end
        end
        start = 1'b0;
        chk({name, "_finished"}, finished, 1);
        chk({name, "_done_count"}, done_n, 1);
        chk({name, "_byte_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), got[i], expq[i]);
        chk({name, "_done_latency"}, done_cyc - xfer_cyc, 1);
        if (mode == 0) chk({name, "_busy_cycles"}, busy_n, 2 * (last + 1) + extra);
        out_ready = 1'b1;
        if (restart_at > 0) begin
            repeat (3) begin
                @(negedge clk);
                chk({name, "_not_queued"}, w_busy, 0);
            end
        end
    endtask

    initial begin
        bit found, saw_done;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; sel = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        #2;
        chk("reset_valid", ov_a, 0);
        chk("reset_busy", bz_a, 0);
        chk("reset_done", dn_a, 0);
        chk("reset_ra", ra_a, 0);
        chk("reset_data", od_a, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) regs[i] = 8'(i * 8'h11);
        run_dump("ramp", 0, 0);

        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[5] = 8'hA5;
        run_dump("a5", 0, 0);

        for (int i = 0; i < 16; i++) regs[i] = 8'(i * 8'h11);
        run_dump("stall", 1, 0);

        fill_random();
        run_dump("restart", 0, 7);

        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_dump($sformatf("rand%0d", k), 2, 0);
        end

        // asynchronous abort while index 9 is on the stream
        for (int i = 0; i < 16; i++) regs[i] = 8'(i * 8'h11);
        out_ready = 1'b1;
        found = 1'b0; saw_done = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (dn_a) saw_done = 1'b1;
            if (ov_a && ra_a == 4'd9) found = 1'b1;
        end
        chk("abort_reach9", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", ov_a, 0);
        chk("abort_busy", bz_a, 0);
        chk("abort_done", dn_a, 0);
        chk("abort_ra", ra_a, 0);
        chk("abort_data", od_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_no_done", saw_done, 0);
        run_dump("after_rst", 0, 0);

        sel = 1'b1;
        fill_random();
        run_dump("last3", 0, 0);
        fill_random();
        run_dump("last3_rand", 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter LAST_REG, default 15: index of the last register dumped; registers 0..LAST_REG are sent in ascending order.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  dump request; sampled only in IDLE.
REQ-005 ra  output  4  register-file read address, driven to the register file's ra port.
REQ-006 read_a  input  8  register-file read data for ra; combinational, valid in the same cycle.
REQ-007 out_data  output  8  byte stream data.
REQ-008 out_valid  output  1  out_data holds a byte to transfer.
REQ-009 out_ready  input  1  sink accepts; transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-012 States: IDLE, FETCH, SEND, CSUM, FIN; state, index counter (4 bits), out_data and the checksum are registers.
REQ-013 IDLE: start=1 moves to FETCH with index=0 and checksum=0x00; start=0 stays in IDLE.
REQ-014 FETCH: ra=index; at the clock edge out_data<=read_a, checksum<=checksum XOR read_a, next state SEND; exactly one cycle.
REQ-015 ra SHALL equal index in every state; its value outside FETCH has no effect on behaviour.
REQ-016 SEND: out_valid=1; out_data SHALL NOT change until the transfer; the state SHALL NOT change while out_ready=0.
REQ-017 SEND transfer with index<LAST_REG: index increments, next state FETCH.
REQ-018 SEND transfer with index==LAST_REG: next state CSUM if REG_DUMP_CSUM_EN is defined, else FIN.
REQ-019 FIN: done=1 for exactly this one cycle, next state IDLE; busy=1 in FIN.
REQ-020 Per register: 1 FETCH cycle plus at least 1 SEND cycle; with out_ready held at 1, a 16-register dump takes 32 cycles from the first FETCH to FIN.
REQ-021 start asserted while busy=1 is ignored and is not queued.
REQ-022 start held high in FIN is not seen; start still high in the following IDLE cycle begins a new dump.
REQ-023 out_valid is 0 in IDLE, FETCH and FIN.
REQ-024 Register 0 reads as 0x00 from the register file and SHALL be sent as an ordinary byte.
REQ-025 The index counter SHALL never exceed LAST_REG, and SHALL NOT wrap.

Reset
REQ-026 rst=1 forces, immediately and asynchronously, state=IDLE, index=0, out_data=0x00, checksum=0x00, out_valid=0, busy=0, done=0, ra=0.
REQ-027 rst during a dump aborts it with no done pulse; the first dump after release starts again at register 0.

Configuration
REQ-028 Macro REG_DUMP_CSUM_EN: when defined, CSUM state exists; when undefined, CSUM and its logic are absent and SEND goes straight to FIN.
REQ-029 CSUM: out_valid=1, out_data=checksum, which is the XOR of all register bytes sent; held until the transfer, then next state FIN.
REQ-030 With the macro defined, a dump is LAST_REG+2 bytes; without it, LAST_REG+1 bytes.

Verification
REQ-031 Regs r1..r15=0x11,0x22,...,0xFF, out_ready=1, pulse start -> bytes 00,11,22,...,FF in order, done one cycle after the last transfer, 32 busy cycles before FIN (macro off).
REQ-032 Same data, macro on -> 17th byte = 0x11^0x22^...^0xFF = 0x00; r5=0xA5 and all others 0 -> bytes 00,00,00,00,00,A5,00,...,00 then A5.
REQ-033 out_ready toggles 0,0,1 repeatedly -> out_data stable while stalled, no byte lost or duplicated, 16 bytes total.
REQ-034 start pulsed again at byte 7 -> ignored; exactly one done pulse and 16 bytes.
REQ-035 rst asserted mid-SEND at index 9 -> out_valid and busy drop in the same cycle with no clock edge; the next start produces 00 first and a full dump.
REQ-036 LAST_REG=3, out_ready=1 -> exactly 4 bytes (r0..r3), and ra never exceeds 3.
